// File: rtl/apu_telemetry_tx.sv
// UART dump transmitter: snapshots the 16 APU register bytes on request and sends
// an 8N1 frame of SYNC, 16 register bytes and an 8-bit additive checksum.
module apu_telemetry_tx #(
    parameter int CLKRATE  = 1_790_000,
    parameter int BAUDRATE = 9600,
    parameter int DIVISOR  = CLKRATE / BAUDRATE,
    parameter logic [7:0] SYNC = 8'hA5
) (
    input  logic         apu_clk,
    input  logic         rst_n,
    input  logic         dump_req,
    input  logic [127:0] reg_data,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam logic [11:0] RELOAD   = 12'(DIVISOR - 1);
    localparam logic [4:0]  LAST_BYTE = 5'd17;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state_q;
    logic [11:0]    cnt_q;
    logic [2:0]     bit_q;
    logic [4:0]     byte_q;
    logic [127:0]   snap_q;
    logic [7:0]     csum_q;
    logic           tx_q, busy_q, done_q;

    logic [7:0]     sum_d;
    logic [7:0]     cur_byte;
    logic [2:0]     bit_nx;
    logic           bit_end;

    // Checksum is taken from the live bus so it lands in the same edge as the snapshot.
    always_comb begin
        sum_d = 8'h00;
        for (int i = 0; i < 16; i++) sum_d = sum_d + reg_data[8*i +: 8];
    end

    always_comb begin
        cur_byte = SYNC;
        if (byte_q == LAST_BYTE) cur_byte = csum_q;
        for (int i = 0; i < 16; i++)
            if (byte_q == 5'(i + 1)) cur_byte = snap_q[8*i +: 8];
    end

    assign bit_nx  = bit_q + 3'd1;
    assign bit_end = (cnt_q == 12'd0);

    always_ff @(posedge apu_clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 12'd0;
            bit_q   <= 3'd0;
            byte_q  <= 5'd0;
            snap_q  <= '0;
            csum_q  <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (dump_req) begin
                        snap_q  <= reg_data;
                        csum_q  <= sum_d;
                        byte_q  <= 5'd0;
                        bit_q   <= 3'd0;
                        cnt_q   <= RELOAD;
                        busy_q  <= 1'b1;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_q   <= RELOAD;
                        bit_q   <= 3'd0;
                        tx_q    <= cur_byte[0];
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q - 12'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= RELOAD;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_nx;
                            tx_q  <= cur_byte[bit_nx];
                        end
                    end else begin
                        cnt_q <= cnt_q - 12'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (byte_q < LAST_BYTE) begin
                            byte_q  <= byte_q + 5'd1;
                            cnt_q   <= RELOAD;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            cnt_q   <= 12'd0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 12'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_apu_telemetry_tx.sv
// Bench for apu_telemetry_tx: a frame-level model predicts tx/busy/done every cycle.
module tb_apu_telemetry_tx;

    localparam int DIV   = 5;
    localparam int FRAME = 180 * DIV;

    logic         apu_clk = 1'b0;
    logic         rst_n;
    logic         dump_req;
    logic [127:0] reg_data;
    logic         tx, busy, done;

    int checks = 0;
    int errors = 0;

    // model state
    logic [7:0] m_frame [18];
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    int         m_t    = 0;
    int         cyc    = 0;
    int         acc_cyc = 0;
    int         done_cyc = 0;
    int         done_cnt = 0;

    apu_telemetry_tx #(.DIVISOR(DIV)) dut (
        .apu_clk  (apu_clk),
        .rst_n    (rst_n),
        .dump_req (dump_req),
        .reg_data (reg_data),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 apu_clk = ~apu_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // Frame bit k: start 0, 8 data bits LSB first, stop 1, for byte k/10.
    function automatic logic fbit(input int k);
        int b;
        logic [7:0] v;
        b = k % 10;
        v = m_frame[k / 10];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return v[b - 1];
    endfunction

    task automatic model_accept();
        logic [7:0] s;
        s = 8'h00;
        m_frame[0] = 8'hA5;
        for (int i = 0; i < 16; i++) begin
            m_frame[i + 1] = reg_data[8*i +: 8];
            s = s + reg_data[8*i +: 8];
        end
        m_frame[17] = s;
    endtask

    task automatic compare_loop();
        forever begin
            @(posedge apu_clk);
            cyc++;
            m_done = 1'b0;
            if (!rst_n) begin
                m_busy = 1'b0;
            end else if (!m_busy) begin
                if (dump_req) begin
                    model_accept();
                    m_busy  = 1'b1;
                    m_t     = 0;
                    acc_cyc = cyc;
                end
            end else begin
                m_t++;
                if (m_t == FRAME) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
            #1;
            chk("tx",   32'(tx),   32'(m_busy ? fbit(m_t / DIV) : 1'b1));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    endtask

    task automatic pulse_req();
        @(negedge apu_clk); dump_req = 1'b1;
        @(negedge apu_clk); dump_req = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge apu_clk);
            n++;
        end
        chk("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        logic [9:0] bits;
        int d0;

        rst_n    = 1'b0;
        dump_req = 1'b0;
        reg_data = '0;
        fork compare_loop(); join_none
        repeat (3) @(negedge apu_clk);
        chk("rst_tx",   32'(tx),   32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge apu_clk);

        // All-zero registers: SYNC, zeros, zero checksum; first byte bit-exact.
        pulse_req();
        for (int k = 0; k < 10; k++) begin
            bits[k] = tx;
            repeat (DIV) @(negedge apu_clk);
        end
        chk("first_bits", 32'(bits), 32'h34A);
        chk("zero_sync", 32'(m_frame[0]), 32'hA5);
        chk("zero_csum", 32'(m_frame[17]), 32'h00);
        wait_done(2 * FRAME);
        chk("frame_len", 32'(done_cyc - acc_cyc), 32'(FRAME));
        repeat (3) @(negedge apu_clk);

        // Ramp pattern, overwritten right after accept: snapshot must hold.
        for (int i = 0; i < 16; i++) reg_data[8*i +: 8] = 8'(i * 17);
        @(negedge apu_clk); dump_req = 1'b1;
        @(negedge apu_clk); dump_req = 1'b0; reg_data = '1;
        chk("ramp_csum", 32'(m_frame[17]), 32'hF8);
        chk("ramp_last", 32'(m_frame[16]), 32'hFF);
        wait_done(2 * FRAME);
        repeat (3) @(negedge apu_clk);

        // Requests while busy are dropped.
        d0 = done_cnt;
        reg_data = {4{$urandom()}};
        pulse_req();
        repeat (200) @(negedge apu_clk);
        pulse_req();
        repeat (400) @(negedge apu_clk);
        pulse_req();
        wait_done(2 * FRAME);
        repeat (20) @(negedge apu_clk);
        chk("busy_ignored", 32'(done_cnt - d0), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);

        // Held request: one idle-high cycle between frames.
        @(negedge apu_clk); dump_req = 1'b1;
        wait_done(2 * FRAME);
        chk("b2b_gap_tx",   32'(tx),   32'd1);
        chk("b2b_gap_busy", 32'(busy), 32'd0);
        @(negedge apu_clk);
        chk("b2b_start_tx",   32'(tx),   32'd0);
        chk("b2b_start_busy", 32'(busy), 32'd1);
        dump_req = 1'b0;
        wait_done(2 * FRAME);
        repeat (3) @(negedge apu_clk);

        // Reset during byte 5, bit 3.
        d0 = done_cnt;
        pulse_req();
        repeat ((5 * 10 + 4) * DIV) @(negedge apu_clk);
        rst_n = 1'b0;
        @(negedge apu_clk);
        chk("midrst_tx",   32'(tx),   32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (FRAME) @(negedge apu_clk);
        chk("midrst_nodone", 32'(done_cnt - d0), 32'd0);
        reg_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        pulse_req();
        wait_done(2 * FRAME);
        chk("midrst_recover", 32'(done_cnt - d0), 32'd1);
        repeat (2) @(negedge apu_clk);

        // Random frames with bus churn and stray requests.
        for (int f = 0; f < 4; f++) begin
            reg_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            pulse_req();
            for (int c = 0; c < FRAME - 100; c++) begin
                @(negedge apu_clk);
                reg_data[32*$urandom_range(0, 3) +: 32] = $urandom();
                dump_req = ($urandom_range(0, 15) == 0);
            end
            dump_req = 1'b0;
            wait_done(2 * FRAME);
            repeat ($urandom_range(1, 5)) @(negedge apu_clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
